// File: rtl/instr_loader.sv
// Bit-serial to word loader: 9-bit frames, MSB first, are queued in a DEPTH-word FIFO and issued as write_en pulses, 2 cycles from the last bit when idle.
// HOLD stalls issue, and a frame that lands on a full FIFO is dropped with sticky OVERFLOW. LOADER_PARITY_EN adds an even-parity bit per frame and PERR_CNT.
module instr_loader #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SDATA,
  input  logic             SVALID,
  input  logic             SFRAME,
  input  logic             HOLD,
  output logic [WIDTH-1:0] INSTRUCTION,
  output logic             write_en,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic [7:0]       PERR_CNT
);

`ifdef LOADER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_M1   = CW'(FRAME_LEN - 1);
  localparam logic [AW:0]   DEPTH_OCC = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [CW-1:0]        bit_cnt;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          occ;
  logic [AW:0]          occ_nxt;
  logic [WIDTH-1:0]     frame_word;
  logic                 frame_ok;
  logic                 push;
  logic                 pop;
  logic                 accept;

`ifdef LOADER_PARITY_EN
  assign frame_word = shreg[FRAME_LEN-1:1];
  assign frame_ok   = ~(^shreg);
`else
  assign frame_word = shreg;
  assign frame_ok   = 1'b1;
`endif

  assign push   = (state == CHECK) && frame_ok;
  assign pop    = !EMPTY && !HOLD;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign accept = push && (!FULL || pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (SVALID && SFRAME) begin
            shreg   <= {{(FRAME_LEN-1){1'b0}}, SDATA};
            bit_cnt <= CW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (SVALID) begin
            if (SFRAME) begin
              shreg   <= {{(FRAME_LEN-1){1'b0}}, SDATA};
              bit_cnt <= CW'(1);
            end else begin
              shreg   <= {shreg[FRAME_LEN-2:0], SDATA};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_M1) state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (SVALID && SFRAME) begin
            shreg   <= {{(FRAME_LEN-1){1'b0}}, SDATA};
            bit_cnt <= CW'(1);
            state   <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({accept, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      EMPTY       <= 1'b1;
      FULL        <= 1'b0;
      OVERFLOW    <= 1'b0;
      write_en    <= 1'b0;
      INSTRUCTION <= '0;
    end else begin
      write_en <= pop;
      if (pop) begin
        INSTRUCTION <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (push && FULL && !pop) OVERFLOW <= 1'b1;
      occ   <= occ_nxt;
      EMPTY <= (occ_nxt == '0);
      FULL  <= (occ_nxt == DEPTH_OCC);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= frame_word;
  end

`ifdef LOADER_PARITY_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PERR_CNT <= 8'h00;
    end else if ((state == CHECK) && !frame_ok && (PERR_CNT != 8'hFF)) begin
      PERR_CNT <= PERR_CNT + 1'b1;
    end
  end
`else
  assign PERR_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a queue-level model of the FIFO and issue rules is compared with every DUT output each cycle, and directed literal checks pin that model.
module tb_instr_loader;
  localparam int DEPTH = 4;
  localparam int WIDTH = 9;
`ifdef LOADER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic SDATA = 1'b0;
  logic SVALID = 1'b0;
  logic SFRAME = 1'b0;
  logic HOLD = 1'b0;
  logic [WIDTH-1:0] INSTRUCTION;
  logic write_en, EMPTY, FULL, OVERFLOW;
  logic [7:0] PERR_CNT;

  instr_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SDATA(SDATA), .SVALID(SVALID), .SFRAME(SFRAME),
    .HOLD(HOLD), .INSTRUCTION(INSTRUCTION), .write_en(write_en), .EMPTY(EMPTY),
    .FULL(FULL), .OVERFLOW(OVERFLOW), .PERR_CNT(PERR_CNT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: queued words, expected output registers, one pending completed frame.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_ins;
  logic m_wen, m_ovf;
  int m_perr;
  logic pend, pend_ok;
  logic [WIDTH-1:0] pend_word;

  logic [WIDTH-1:0] pq[$];
  int pulses, last_pulse_cyc, last_bit_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ins = '0; m_wen = 1'b0; m_ovf = 1'b0; m_perr = 0; pend = 1'b0;
  endtask

  task automatic compare();
    chk("write_en", write_en, m_wen);
    chk("INSTRUCTION", INSTRUCTION, m_ins);
    chk("EMPTY", EMPTY, mq.size() == 0);
    chk("FULL", FULL, mq.size() == DEPTH);
    chk("OVERFLOW", OVERFLOW, m_ovf);
    chk("PERR_CNT", PERR_CNT, m_perr);
    if (write_en === 1'b1) begin
      pulses++;
      pq.push_back(INSTRUCTION);
      last_pulse_cyc = cyc;
    end
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (RESET_N) begin
      m_wen = 1'b0;
      if (mq.size() != 0 && !HOLD) begin
        m_ins = mq.pop_front();
        m_wen = 1'b1;
      end
      if (pend) begin
        if (!pend_ok) m_perr = (m_perr < 255) ? m_perr + 1 : 255;
        else if (mq.size() < DEPTH) mq.push_back(pend_word);
        else m_ovf = 1'b1;
        pend = 1'b0;
      end
    end
    @(negedge CLK);
    compare();
  endtask

  task automatic idle(input int n);
    SVALID = 1'b0; SFRAME = 1'b0; SDATA = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [WIDTH-1:0] word, input bit bad = 1'b0, input bit rel_hold = 1'b0);
    logic [FL-1:0] f;
`ifdef LOADER_PARITY_EN
    f = {word, (^word) ^ bad};
`else
    f = word;
`endif
    for (int i = 0; i < FL; i++) begin
      SVALID = 1'b1; SFRAME = (i == 0); SDATA = f[FL-1-i];
      tick();
    end
    last_bit_cyc = cyc;
    pend = 1'b1; pend_word = word; pend_ok = !bad;
    if (rel_hold) HOLD = 1'b0;
    SVALID = 1'b0; SFRAME = 1'b0; SDATA = 1'b0;
  endtask

  task automatic send_partial(input logic [WIDTH-1:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      SVALID = 1'b1; SFRAME = (i == 0); SDATA = word[WIDTH-1-i];
      tick();
    end
  endtask

  task automatic reset_dut();
    RESET_N = 1'b0;
    model_reset();
    SVALID = 1'b0; SFRAME = 1'b0; SDATA = 1'b0;
    tick();
    RESET_N = 1'b1;
    pulses = 0;
    pq.delete();
  endtask

  initial begin
    model_reset();
    pulses = 0; last_pulse_cyc = 0; last_bit_cyc = 0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Single frame, latency and return to empty.
    pulses = 0; pq.delete();
    send(9'h1A5);
    idle(4);
    chk("t1_pulses", pulses, 1);
    chk("t1_word", pq[0], 9'h1A5);
    chk("t1_latency", last_pulse_cyc - last_bit_cyc, 2);
    chk("t1_empty", EMPTY, 1);

    // Fill under HOLD, overflow on the fifth word, then drain.
    HOLD = 1'b1; pulses = 0; pq.delete();
    for (int w = 1; w <= 4; w++) send(WIDTH'(w));
    tick();
    chk("t2_full", FULL, 1);
    chk("t2_no_ovf_yet", OVERFLOW, 0);
    send(9'h005);
    tick();
    chk("t2_ovf", OVERFLOW, 1);
    HOLD = 1'b0;
    idle(6);
    chk("t2_pulses", pulses, 4);
    for (int k = 0; k < 4; k++) chk("t2_order", pq[k], k + 1);
    chk("t2_empty", EMPTY, 1);

    // Full FIFO, completing frame coincides with the first pop.
    HOLD = 1'b1;
    reset_dut();
    send(9'h011); send(9'h022); send(9'h033); send(9'h044);
    send(9'h055, 1'b0, 1'b1);
    idle(8);
    chk("t3_pulses", pulses, 5);
    chk("t3_ovf", OVERFLOW, 0);
    chk("t3_first", pq[0], 9'h011);
    chk("t3_last", pq[4], 9'h055);

    // Frame restarted after 5 bits.
    pulses = 0; pq.delete();
    send_partial(9'h1C3, 5);
    send(9'h0FF);
    idle(4);
    chk("t4_pulses", pulses, 1);
    chk("t4_word", pq[0], 9'h0FF);

    // Asynchronous reset mid-frame with two words queued.
    HOLD = 1'b1;
    send(9'h101); send(9'h102);
    send_partial(9'h1C3, 4);
    #2 RESET_N = 1'b0;
    #1;
    chk("t5_rst_write_en", write_en, 0);
    chk("t5_rst_instr", INSTRUCTION, 0);
    chk("t5_rst_empty", EMPTY, 1);
    chk("t5_rst_full", FULL, 0);
    chk("t5_rst_ovf", OVERFLOW, 0);
    model_reset();
    idle(1);
    RESET_N = 1'b1; HOLD = 1'b0; pulses = 0; pq.delete();
    for (int i = 0; i < WIDTH; i++) begin
      SVALID = 1'b1; SFRAME = 1'b0; SDATA = 1'b1;
      tick();
    end
    idle(6);
    chk("t5_no_pulse", pulses, 0);
    send(9'h0A5);
    idle(4);
    chk("t5_new_pulses", pulses, 1);
    chk("t5_new_word", pq[0], 9'h0A5);

`ifdef LOADER_PARITY_EN
    // Parity acceptance, rejection and counter saturation.
    HOLD = 1'b0;
    reset_dut();
    send(9'h003);
    idle(4);
    chk("t6_good_pulses", pulses, 1);
    chk("t6_good_word", pq[0], 9'h003);
    send(9'h003, 1'b1);
    idle(4);
    chk("t6_bad_pulses", pulses, 1);
    chk("t6_perr1", PERR_CNT, 1);
    HOLD = 1'b1;
    for (int w = 0; w < 4; w++) send(WIDTH'(w + 8));
    for (int b = 0; b < 300; b++) send(WIDTH'(b), 1'b1);
    idle(2);
    chk("t6_perr_sat", PERR_CNT, 255);
    chk("t6_no_ovf", OVERFLOW, 0);
    HOLD = 1'b0;
    idle(6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary by %0t", $time);
    $fatal(1);
  end

endmodule
